// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encoding, FSM state type and the iterative-op predicate
// shared by the alu_seq top and its multiply/divide unit.
// Build option: define ALU_SEQ_DIV_EN to include the divider (DIV/DIVU).
package alu_seq_pkg;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0010;
  localparam logic [3:0] ALUC_OR   = 4'b0011;
  localparam logic [3:0] ALUC_XOR  = 4'b0100;
  localparam logic [3:0] ALUC_NOR  = 4'b0101;
  localparam logic [3:0] ALUC_SLT  = 4'b0110;
  localparam logic [3:0] ALUC_SLTU = 4'b0111;
  localparam logic [3:0] ALUC_SLL  = 4'b1000;
  localparam logic [3:0] ALUC_SRL  = 4'b1001;
  localparam logic [3:0] ALUC_SRA  = 4'b1010;
  localparam logic [3:0] ALUC_RSVD = 4'b1011;
  localparam logic [3:0] ALUC_MUL  = 4'b1100;
  localparam logic [3:0] ALUC_MULU = 4'b1101;
  localparam logic [3:0] ALUC_DIV  = 4'b1110;
  localparam logic [3:0] ALUC_DIVU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for opcodes that run through the WIDTH-cycle multiply/divide unit.
  // Without the divider, DIV/DIVU fall back to single-cycle reserved ops.
  function automatic logic is_iter(input logic [3:0] aluc);
`ifdef ALU_SEQ_DIV_EN
    return aluc[3:2] == 2'b11;
`else
    return (aluc == ALUC_MUL) || (aluc == ALUC_MULU);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/response bundle between the control unit (master) and
// the EX-stage ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 32);

  logic             start;
  logic [3:0]       aluc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] hi;
  logic             z;

  modport master (output start, aluc, a, b, input busy, done, r, hi, z);
  modport slave  (input start, aluc, a, b, output busy, done, r, hi, z);

endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider.
// Both work on operand magnitudes; signs are reapplied on the result path.
// The product/quotient-remainder share the acc_hi/acc_lo register pair, so
// {res_hi,res_lo} is {product} for MUL* and {remainder,quotient} for DIV*.
// Build option: ALU_SEQ_DIV_EN adds the divide datapath.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod_neg;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
`ifdef ALU_SEQ_DIV_EN
  logic             neg_r;
  logic [WIDTH:0]   trial;
`endif

  assign op_signed = ~op[0];
  assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign fin       = running && (cnt == CW'(WIDTH - 1));

  // One iteration of the selected algorithm, computed from the current registers.
  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    sum     = '0;
`ifdef ALU_SEQ_DIV_EN
    trial   = '0;
`endif
    if (op_q[1]) begin
`ifdef ALU_SEQ_DIV_EN
      trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
`endif
    end else begin
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      {step_hi, step_lo} = {sum, acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step so the top can capture it on the fin cycle.
  always_comb begin
    prod_neg = -{step_hi, step_lo};
    {res_hi, res_lo} = {step_hi, step_lo};
    if (op_q == 2'b00 && neg_q) begin
      {res_hi, res_lo} = prod_neg;
    end
`ifdef ALU_SEQ_DIV_EN
    if (op_q == 2'b10) begin
      res_lo = neg_q ? -step_lo : step_lo;
      res_hi = neg_r ? -step_hi : step_hi;
    end
`endif
  end

  // Load magnitudes on start, then step once per cycle for WIDTH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      op_q    <= 2'b00;
      neg_q   <= 1'b0;
      opb     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
`ifdef ALU_SEQ_DIV_EN
      neg_r   <= 1'b0;
`endif
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_q    <= op;
      neg_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      opb     <= mag_b;
      acc_hi  <= '0;
      acc_lo  <= mag_a;
`ifdef ALU_SEQ_DIV_EN
      neg_r   <= op_signed & a[WIDTH-1];
`endif
    end else if (running) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CW'(1);
      if (fin) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU. Single-cycle ops are computed inline and
// registered at accept; MUL*/DIV* run through alu_seq_muldiv for WIDTH cycles.
// Build option: define ALU_SEQ_DIV_EN to enable DIV/DIVU; otherwise they
// behave as reserved opcodes (r=0, hi=0) with single-cycle latency.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             div_zero;
  logic             go_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_r;
  logic [WIDTH-1:0] op_hi;
  logic             md_fin;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] hi_q;
  logic             z_q;

  assign accept = (state_q == IDLE) && bus.start;
  assign shamt  = bus.b[SHW-1:0];
`ifdef ALU_SEQ_DIV_EN
  assign div_zero = (bus.aluc[3:1] == 3'b111) && (bus.b == '0);
`else
  assign div_zero = 1'b0;
`endif
  assign go_iter = accept && is_iter(bus.aluc) && !div_zero;

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.r    = r_q;
  assign bus.hi   = hi_q;
  assign bus.z    = z_q;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (go_iter),
    .op     (bus.aluc[1:0]),
    .a      (bus.a),
    .b      (bus.b),
    .fin    (md_fin),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: single-cycle ops go straight to DONE, iterative ones via CALC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = go_iter ? CALC : DONE;
      CALC:    if (md_fin) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results, including the divide-by-zero shortcut.
  always_comb begin
    op_r  = '0;
    op_hi = '0;
    case (bus.aluc)
      ALUC_ADD:  op_r = bus.a + bus.b;
      ALUC_SUB:  op_r = bus.a - bus.b;
      ALUC_AND:  op_r = bus.a & bus.b;
      ALUC_OR:   op_r = bus.a | bus.b;
      ALUC_XOR:  op_r = bus.a ^ bus.b;
      ALUC_NOR:  op_r = ~(bus.a | bus.b);
      ALUC_SLT:  op_r = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALUC_SLTU: op_r = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      ALUC_SLL:  op_r = bus.a << shamt;
      ALUC_SRL:  op_r = bus.a >> shamt;
      ALUC_SRA:  op_r = $unsigned($signed(bus.a) >>> shamt);
`ifdef ALU_SEQ_DIV_EN
      ALUC_DIV, ALUC_DIVU: begin
        if (div_zero) begin
          op_r  = '1;
          op_hi = bus.a;
        end
      end
`endif
      default: ;
    endcase
  end

  // Result registers: hold until the next op completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= '0;
      hi_q <= '0;
      z_q  <= 1'b1;
    end else if (accept && !go_iter) begin
      r_q  <= op_r;
      hi_q <= op_hi;
      z_q  <= (op_r == '0);
    end else if (state_q == CALC && md_fin) begin
      r_q  <= md_lo;
      hi_q <= md_hi;
      z_q  <= (md_lo == '0);
    end
  end

endmodule
